torv_csr_trap: RTL and testbench
================================

Name: torv_csr_trap

Overview:
Machine-mode CSR file and trap controller for the torv32 five-stage RV32I pipeline. It replaces the ad-hoc MEPC/MCAUSE/MTVEC logic scattered across the stages with one block. The block owns exception entry, interrupt entry and MRET return, and issues a single registered PC redirect to fetch. CSR access comes from the writeback stage. Trap and return requests come from the execute stage.

Parameters:
MTVEC_RESET, 32'h0003_0100, reset value of mtvec (direct mode)
NUM_IRQ, 4, number of external interrupt lines; they are OR-reduced into mip.MEIP
IRQ_SYNC_STAGES, 2, synchroniser depth for irq and timer_irq (range 1..3)
COUNTER_WIDTH, 64, width of cycle/instret (range 32..64); hi CSRs read 0 above the width
VECTORED_EN, 1, when 1, mtvec.MODE=1 is honoured; when 0, MODE bits are WARL and forced to 0

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
csr_en  in  1  CSR instruction in writeback
csr_op  in  2  01 write, 10 set, 11 clear, 00 read-only
csr_addr  in  12  CSR address
csr_wdata  in  32  rs1 value or zero-extended uimm
csr_rdata  out  32  old CSR value, registered, valid the cycle after csr_en
csr_illegal  out  1  registered pulse: unknown address, or write to read-only CSR
exc_valid  in  1  synchronous exception in execute
exc_cause  in  4  cause code: 0 misaligned fetch, 2 illegal, 3 ebreak, 11 ecall
exc_pc  in  32  PC of the faulting instruction
exc_tval  in  32  mtval value
mret  in  1  MRET in execute
commit_valid  in  1  execute holds a non-NOP, non-stalled instruction that is interruptible
commit_pc  in  32  PC of that instruction
instret_inc  in  1  one instruction retired this cycle
irq  in  NUM_IRQ  asynchronous external interrupt lines
timer_irq  in  1  asynchronous timer interrupt
redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc and pipeline flushes
redirect_pc  out  32  target address

Behaviour:
- Reset (resetn=0 at a clk edge) clears everything except mtvec:
  - mstatus.MIE=0, MPIE=0; mie, mepc, mcause, mtval, mscratch, cycle, instret = 0.
  - mtvec = MTVEC_RESET.
  - All outputs 0; synchroniser flops cleared.
  - Reset mid-trap cancels any pending redirect.
- Implemented CSRs:
  - 0x300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11; all other bits 0.
  - 0x304 mie: MEIE bit11, MTIE bit7 writable.
  - 0x344 mip: read-only; MEIP bit11 = |irq_sync, MTIP bit7 = timer_sync.
  - 0x305 mtvec, 0x340 mscratch, 0x341 mepc ([1:0] read 0), 0x342 mcause, 0x343 mtval.
  - 0xC00/0xC80 cycle lo/hi, 0xC02/0xC82 instret lo/hi: read-only.
- CSR access rules:
  - New value = wdata, old|wdata, or old&~wdata according to csr_op.
  - csr_op=00 never writes and never flags read-only violations.
  - csr_illegal=1 for an unknown address, or for csr_op≠00 on mip or 0xCxx. No state changes in that case.
- Counters:
  - cycle increments every non-reset cycle.
  - instret increments when instret_inc=1.
  - Both wrap modulo 2^COUNTER_WIDTH.
- Event priority within one cycle: exc_valid > interrupt > mret > CSR write. A CSR write coinciding with a trap or mret is dropped. A CSR read still returns the old value.
- Exception entry (cycle N):
  - mepc<=exc_pc, mcause<={1'b0,27'b0,exc_cause}, mtval<=exc_tval.
  - MPIE<=MIE, MIE<=0.
  - At N+1: redirect_valid=1, redirect_pc=mtvec base ({mtvec[31:2],2'b00}).
- Interrupt entry:
  - Taken when commit_valid & MIE & |(mip & mie) & !exc_valid.
  - Code 11 (external) has priority over code 7 (timer).
  - mepc<=commit_pc, mcause<={1'b1,27'b0,code}, mtval<=0, MPIE<=MIE, MIE<=0.
  - redirect_pc = base + 4*code when MODE=1 and VECTORED_EN=1, else base.
- MRET: MIE<=MPIE, MPIE<=1; at N+1 redirect_valid=1, redirect_pc=mepc.
- redirect_valid is exactly one cycle. Back-to-back events issue back-to-back redirects; the last one wins.
- Interrupt latency:
  - irq edge to mip visible: IRQ_SYNC_STAGES cycles.
  - mip visible to redirect_valid: 1 cycle, provided commit_valid.
- Level-sensitive irq: pending stays set until the source deasserts. Software masks it via mie or MIE.

Decomposition:
- Package torv_csr_pkg holds:
  - CSR address localparams.
  - Cause codes: CAUSE_MISALIGN=0, ILLEGAL=2, EBREAK=3, ECALL=11, IRQ_TIMER=7, IRQ_EXT=11.
  - csr_op encodings.
  - mstatus/mip bit indices.
- One sub-module, torv_irq_sync: a WIDTH-wide, IRQ_SYNC_STAGES-deep flop synchroniser with synchronous clear. It is instantiated for {timer_irq, irq}.

Test Plan:
1. Reset then read each CSR → mtvec=0x0003_0100, mstatus=0x0000_1800, all others 0, csr_illegal=0.
2. Exception entry: exc_valid, cause=2, exc_pc=0x0003_0040, tval=0xDEAD_BEEF with MIE=1 → next cycle redirect_valid=1, redirect_pc=0x0003_0100; mepc=0x0003_0040, mcause=2, mtval=0xDEAD_BEEF, MIE=0, MPIE=1.
3. Vectored interrupt: mtvec=0x0003_0201, mie=0x800, MIE=1, irq[2] rises, commit_pc=0x0003_0010 → redirect after 2+1 cycles to 0x0003_022C; mcause=0x8000_000B, mepc=0x0003_0010.
4. Masking: timer_irq and irq both asserted with only MTIE set → cause 0x8000_0007. Then MRET → redirect_pc=mepc, MIE=1, MPIE=1.
5. Collision: exc_valid, mret and a write to mscratch in the same cycle → exception taken, mscratch unchanged, exactly one redirect pulse.
6. Illegal and counters: write 0xC00 → csr_illegal=1 with cycle still counting. COUNTER_WIDTH=32 with preload wrap → cycle lo wraps 0xFFFF_FFFF→0, hi reads 0.

Source files
------------

// File: rtl/torv_csr_pkg.sv
// Shared definitions for the torv32 machine-mode CSR file and trap controller.
package torv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [3:0] CAUSE_MISALIGN  = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_ECALL     = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIP_MTIP     = 7;
  localparam int unsigned MIP_MEIP     = 11;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    TRAP_IDLE     = 1'b0,
    TRAP_REDIRECT = 1'b1
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input csr_op_e op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_WRITE: csr_apply = wdata;
      CSR_SET:   csr_apply = old_val | wdata;
      CSR_CLEAR: csr_apply = old_val & ~wdata;
      default:   csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/torv_irq_sync.sv
// Multi-stage flop synchroniser for asynchronous interrupt lines, synchronous clear.
module torv_irq_sync #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [IRQ_SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < IRQ_SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < IRQ_SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[IRQ_SYNC_STAGES-1];

endmodule

// File: rtl/torv_csr_trap.sv
// Machine-mode CSR file and trap controller: exception/interrupt entry, MRET,
// and a single registered fetch redirect.
module torv_csr_trap
  import torv_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET     = 32'h0003_0100,
  parameter int unsigned NUM_IRQ         = 4,
  parameter int unsigned IRQ_SYNC_STAGES = 2,
  parameter int unsigned COUNTER_WIDTH   = 64,
  parameter bit          VECTORED_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               csr_en,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               exc_valid,
  input  logic [3:0]         exc_cause,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        exc_tval,
  input  logic               mret,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               instret_inc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               timer_irq,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  logic                     mstatus_mie_q, mstatus_mpie_q;
  logic                     mie_meie_q, mie_mtie_q;
  logic [31:0]              mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [COUNTER_WIDTH-1:0] cycle_q, instret_q;
  logic [63:0]              cycle_ext, instret_ext;
  logic [NUM_IRQ:0]         sync_q;
  logic                     meip, mtip;
  logic [31:0]              mstatus_val, mie_val, mip_val;
  logic [31:0]              csr_old, csr_new;
  logic                     csr_known, csr_ro, csr_wr, csr_illegal_d;
  logic                     irq_ext, irq_tmr, irq_take, trap_evt;
  logic [3:0]               irq_code;
  logic [31:0]              mtvec_base, irq_target;
  trap_state_e              trap_state_q, trap_state_d;

  torv_irq_sync #(
    .WIDTH           (NUM_IRQ + 1),
    .IRQ_SYNC_STAGES (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      ({timer_irq, irq}),
    .q      (sync_q)
  );

  assign meip = |sync_q[NUM_IRQ-1:0];
  assign mtip = sync_q[NUM_IRQ];

  // Zero-extend so the hi halves read 0 for narrow counters without a generate.
  assign cycle_ext   = 64'(cycle_q);
  assign instret_ext = 64'(instret_q);

  always_comb begin
    mstatus_val               = '0;
    mstatus_val[12:11]        = 2'b11;
    mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
    mie_val                   = '0;
    mie_val[MIP_MEIP]         = mie_meie_q;
    mie_val[MIP_MTIP]         = mie_mtie_q;
    mip_val                   = '0;
    mip_val[MIP_MEIP]         = meip;
    mip_val[MIP_MTIP]         = mtip;
  end

  always_comb begin
    csr_old   = '0;
    csr_known = 1'b1;
    csr_ro    = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  csr_old = mstatus_val;
      CSR_MIE:      csr_old = mie_val;
      CSR_MTVEC:    csr_old = mtvec_q;
      CSR_MSCRATCH: csr_old = mscratch_q;
      CSR_MEPC:     csr_old = mepc_q;
      CSR_MCAUSE:   csr_old = mcause_q;
      CSR_MTVAL:    csr_old = mtval_q;
      CSR_MIP:      begin csr_old = mip_val;             csr_ro = 1'b1; end
      CSR_CYCLE:    begin csr_old = cycle_ext[31:0];     csr_ro = 1'b1; end
      CSR_CYCLEH:   begin csr_old = cycle_ext[63:32];    csr_ro = 1'b1; end
      CSR_INSTRET:  begin csr_old = instret_ext[31:0];   csr_ro = 1'b1; end
      CSR_INSTRETH: begin csr_old = instret_ext[63:32];  csr_ro = 1'b1; end
      default:      csr_known = 1'b0;
    endcase
  end

  // Priority: exception > interrupt > mret > CSR write.
  always_comb begin
    irq_ext       = meip & mie_meie_q;
    irq_tmr       = mtip & mie_mtie_q;
    irq_take      = commit_valid & mstatus_mie_q & (irq_ext | irq_tmr) & ~exc_valid;
    irq_code      = irq_ext ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
    trap_evt      = exc_valid | irq_take | mret;
    mtvec_base    = {mtvec_q[31:2], 2'b00};
    irq_target    = (VECTORED_EN && mtvec_q[0]) ? mtvec_base + {26'b0, irq_code, 2'b00}
                                                : mtvec_base;
    csr_new       = csr_apply(csr_op_e'(csr_op), csr_old, csr_wdata);
    csr_illegal_d = csr_en & (~csr_known | (csr_ro & (csr_op != CSR_READ)));
    csr_wr        = csr_en & (csr_op != CSR_READ) & csr_known & ~csr_ro & ~trap_evt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) trap_state_q <= TRAP_IDLE;
    else         trap_state_q <= trap_state_d;
  end

  always_comb begin
    trap_state_d = trap_evt ? TRAP_REDIRECT : TRAP_IDLE;
  end

  always_comb begin
    redirect_valid = (trap_state_q == TRAP_REDIRECT);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      cycle_q        <= '0;
      instret_q      <= '0;
      csr_rdata      <= '0;
      csr_illegal    <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      cycle_q     <= cycle_q + COUNTER_WIDTH'(1);
      if (instret_inc) instret_q <= instret_q + COUNTER_WIDTH'(1);
      csr_rdata   <= (csr_en && csr_known) ? csr_old : '0;
      csr_illegal <= csr_illegal_d;

      if (exc_valid) begin
        mepc_q         <= {exc_pc[31:2], 2'b00};
        mcause_q       <= {28'b0, exc_cause};
        mtval_q        <= exc_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        redirect_pc    <= mtvec_base;
      end else if (irq_take) begin
        mepc_q         <= {commit_pc[31:2], 2'b00};
        mcause_q       <= {1'b1, 27'b0, irq_code};
        mtval_q        <= '0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
        redirect_pc    <= irq_target;
      end else if (mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
        redirect_pc    <= mepc_q;
      end else if (csr_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_new[MSTATUS_MIE];
            mstatus_mpie_q <= csr_new[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            mie_meie_q <= csr_new[MIP_MEIP];
            mie_mtie_q <= csr_new[MIP_MTIP];
          end
          CSR_MTVEC:    mtvec_q    <= {csr_new[31:2], 1'b0, VECTORED_EN && csr_new[0]};
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= {csr_new[31:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= csr_new;
          CSR_MTVAL:    mtval_q    <= csr_new;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_torv_csr_trap.sv
// Directed self-checking bench for torv_csr_trap (64-bit and 32-bit counter builds).
module tb_torv_csr_trap;
  import torv_csr_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, commit_valid, instret_inc, timer_irq;
  logic [31:0] commit_pc;
  logic [3:0]  irq;

  logic [31:0] csr_rdata, redirect_pc, csr_rdata_w32, redirect_pc_w32;
  logic        csr_illegal, redirect_valid, csr_illegal_w32, redirect_valid_w32;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] rd, rd32, t0, t1;
  logic        ill;
  int          lat;

  always #5 clk = ~clk;

  torv_csr_trap dut (
    .clk(clk), .resetn(resetn), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .instret_inc(instret_inc), .irq(irq), .timer_irq(timer_irq),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  torv_csr_trap #(.COUNTER_WIDTH(32)) dut_w32 (
    .clk(clk), .resetn(resetn), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata_w32), .csr_illegal(csr_illegal_w32),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .instret_inc(instret_inc), .irq(irq), .timer_irq(timer_irq),
    .redirect_valid(redirect_valid_w32), .redirect_pc(redirect_pc_w32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with registered results sampled.
  task automatic csr_do(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    @(negedge clk);
    rd = csr_rdata; rd32 = csr_rdata_w32; ill = csr_illegal;
    csr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_do(CSR_READ, addr, '0);
    check(tag, rd, exp);
  endtask

  task automatic wait_redirect(output int cycles);
    cycles = 0;
    while (!redirect_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    resetn = 1'b0; csr_en = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0; mret = 1'b0;
    commit_valid = 1'b0; commit_pc = '0; instret_inc = 1'b0; irq = '0; timer_irq = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("rst_csr_rdata", csr_rdata, 32'h0);
    resetn = 1'b1;

    // 1: reset values
    check_csr("rst_mtvec", CSR_MTVEC, 32'h0003_0100);
    check_csr("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    check("rst_illegal", {31'b0, ill}, 32'h0);
    check_csr("rst_mie", CSR_MIE, 32'h0);
    check_csr("rst_mip", CSR_MIP, 32'h0);
    check_csr("rst_mepc", CSR_MEPC, 32'h0);
    check_csr("rst_mcause", CSR_MCAUSE, 32'h0);
    check_csr("rst_mtval", CSR_MTVAL, 32'h0);
    check_csr("rst_mscratch", CSR_MSCRATCH, 32'h0);
    check_csr("rst_instret", CSR_INSTRET, 32'h0);

    // 2: exception entry
    csr_do(CSR_WRITE, CSR_MSTATUS, 32'h0000_0008);
    exc_valid = 1'b1; exc_cause = CAUSE_ILLEGAL; exc_pc = 32'h0003_0040; exc_tval = 32'hDEAD_BEEF;
    @(negedge clk);
    exc_valid = 1'b0;
    check("exc_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("exc_redirect_pc", redirect_pc, 32'h0003_0100);
    @(negedge clk);
    check("exc_redirect_pulse", {31'b0, redirect_valid}, 32'h0);
    check_csr("exc_mepc", CSR_MEPC, 32'h0003_0040);
    check_csr("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
    check_csr("exc_mtval", CSR_MTVAL, 32'hDEAD_BEEF);
    check_csr("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // 3: vectored external interrupt
    csr_do(CSR_WRITE, CSR_MTVEC, 32'h0003_0201);
    csr_do(CSR_WRITE, CSR_MIE, 32'h0000_0800);
    csr_do(CSR_SET, CSR_MSTATUS, 32'h0000_0008);
    commit_valid = 1'b1; commit_pc = 32'h0003_0010; irq[2] = 1'b1;
    wait_redirect(lat);
    commit_valid = 1'b0; irq = '0;
    check("irq_latency", 32'(lat), 32'd3);
    check("irq_redirect_pc", redirect_pc, 32'h0003_022C);
    check_csr("irq_mcause", CSR_MCAUSE, 32'h8000_000B);
    check_csr("irq_mepc", CSR_MEPC, 32'h0003_0010);
    repeat (3) @(negedge clk);

    // 4: masking selects timer, then MRET
    csr_do(CSR_WRITE, CSR_MIE, 32'h0000_0080);
    csr_do(CSR_SET, CSR_MSTATUS, 32'h0000_0008);
    commit_valid = 1'b1; commit_pc = 32'h0003_0020; irq[0] = 1'b1; timer_irq = 1'b1;
    wait_redirect(lat);
    commit_valid = 1'b0; irq = '0; timer_irq = 1'b0;
    check("tmr_latency", 32'(lat), 32'd3);
    check("tmr_redirect_pc", redirect_pc, 32'h0003_021C);
    check_csr("tmr_mcause", CSR_MCAUSE, 32'h8000_0007);
    repeat (3) @(negedge clk);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    check("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("mret_redirect_pc", redirect_pc, 32'h0003_0020);
    check_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // 5: exception + mret + CSR write collide
    csr_do(CSR_WRITE, CSR_MSCRATCH, 32'h1234_5678);
    csr_en = 1'b1; csr_op = CSR_WRITE; csr_addr = CSR_MSCRATCH; csr_wdata = 32'hFFFF_FFFF;
    exc_valid = 1'b1; exc_cause = CAUSE_ECALL; exc_pc = 32'h0003_0080; exc_tval = '0; mret = 1'b1;
    @(negedge clk);
    csr_en = 1'b0; exc_valid = 1'b0; mret = 1'b0;
    check("col_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("col_redirect_pc", redirect_pc, 32'h0003_0200);
    check("col_rdata_old", csr_rdata, 32'h1234_5678);
    @(negedge clk);
    check("col_redirect_pulse", {31'b0, redirect_valid}, 32'h0);
    check_csr("col_mscratch", CSR_MSCRATCH, 32'h1234_5678);
    check_csr("col_mcause", CSR_MCAUSE, 32'h0000_000B);
    check_csr("col_mepc", CSR_MEPC, 32'h0003_0080);
    check_csr("col_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // 6: illegal accesses and counters
    csr_do(CSR_READ, CSR_CYCLE, '0);
    check("ro_read_legal", {31'b0, ill}, 32'h0);
    t0 = rd;
    csr_do(CSR_WRITE, CSR_CYCLE, 32'h5);
    check("ro_write_illegal", {31'b0, ill}, 32'h1);
    csr_do(CSR_READ, CSR_CYCLE, '0);
    t1 = rd;
    check("cycle_counting", t1 - t0, 32'd2);
    csr_do(CSR_SET, CSR_MIP, 32'h0000_0800);
    check("mip_write_illegal", {31'b0, ill}, 32'h1);
    csr_do(CSR_READ, 12'h7C0, '0);
    check("unknown_addr_illegal", {31'b0, ill}, 32'h1);
    csr_do(CSR_WRITE, CSR_MTVAL, 32'h0000_0055);
    check("legal_write_clean", {31'b0, ill}, 32'h0);
    check_csr("mtval_clear_op", CSR_MTVAL, 32'h0000_0055);
    csr_do(CSR_CLEAR, CSR_MTVAL, 32'h0000_0005);
    check_csr("mtval_after_clear", CSR_MTVAL, 32'h0000_0050);
    instret_inc = 1'b1;
    repeat (5) @(negedge clk);
    instret_inc = 1'b0;
    check_csr("instret_count", CSR_INSTRET, 32'd5);

    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    force dut_w32.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    release dut_w32.cycle_q;
    csr_do(CSR_READ, CSR_CYCLE, '0);
    check("w32_cycle_max", rd32, 32'hFFFF_FFFF);
    check("w64_cycle_lo_max", rd, 32'hFFFF_FFFF);
    csr_do(CSR_READ, CSR_CYCLE, '0);
    check("w32_cycle_wrap", rd32, 32'h0);
    check("w64_cycle_lo_wrap", rd, 32'h0);
    csr_do(CSR_READ, CSR_CYCLEH, '0);
    check("w32_cycleh_zero", rd32, 32'h0);
    check("w64_cycleh_carry", rd, 32'h1);

    // Reset coinciding with an exception leaves no redirect behind
    exc_valid = 1'b1; exc_cause = CAUSE_EBREAK; resetn = 1'b0;
    @(negedge clk);
    exc_valid = 1'b0;
    check("rst_cancels_redirect", {31'b0, redirect_valid}, 32'h0);
    resetn = 1'b1;
    check_csr("rst_again_mtvec", CSR_MTVEC, 32'h0003_0100);
    check_csr("rst_again_mcause", CSR_MCAUSE, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
